// File: rtl/tft_fb_pkg.sv
// Shared widths, write-buffer entry layout and clear-FSM states for the TFT frame-buffer responder.
package tft_fb_pkg;

    localparam int unsigned FB_ADDR_W = 13;
    localparam int unsigned FB_DATA_W = 8;
    localparam int unsigned WBUF_W    = FB_ADDR_W + FB_DATA_W;

    localparam logic [FB_ADDR_W-1:0] FB_SIZE_DEF = 13'h12C0;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } wbuf_ent_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/tft_fb_wbuf.sv
// Posted-write FIFO between the STN capture writer and the shared frame-buffer SRAM.
module tft_fb_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_x,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign head_data = mem_r[rptr_r[AW-1:0]];
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok) wptr_r <= wptr_r + (AW+1)'(1);
            if (pop_ok)  rptr_r <= rptr_r + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_r[wptr_r[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tft_fb_resp.sv
// Frame-buffer read responder: display reads win the SRAM port, then the clear sweep, then buffered writes.
// Optional clear sweep enabled by defining TFT_FB_CLEAR_EN.
module tft_fb_resp
    import tft_fb_pkg::*;
#(
    parameter logic [FB_ADDR_W-1:0] FB_SIZE    = FB_SIZE_DEF,
    parameter int unsigned          WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        fifo_rdreq,
    input  logic [12:0] fifo_raddr,
    output logic        fifo_rdack,
    output logic [7:0]  fifo_rdata,
    input  logic        wr_req,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_oor,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    wbuf_ent_t            push_ent;
    wbuf_ent_t            head_ent;
    logic                 wbuf_full;
    logic                 wbuf_empty;
    logic                 drain;
    logic                 head_in_rng;
    logic                 rd_in_rng;
    logic                 sweep_busy;
    logic                 sweep_wr;
    logic [FB_ADDR_W-1:0] sweep_addr;
    logic                 rd_vld_r;
    logic [FB_DATA_W-1:0] hold_r;
    logic [FB_ADDR_W-1:0] addr_r;
    logic [FB_DATA_W-1:0] wdata_r;

    assign fifo_rdack = fifo_rdreq;
    assign wr_ack     = wr_req & ~wbuf_full;
    assign rd_in_rng  = (fifo_raddr < FB_SIZE);
    assign push_ent   = '{addr: wr_addr, data: wr_data};

    tft_fb_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (WBUF_W)
    ) u_wbuf (
        .clk       (clk),
        .rst_x     (rst_x),
        .push      (wr_ack),
        .push_data (push_ent),
        .pop       (drain),
        .head_data (head_ent),
        .full      (wbuf_full),
        .empty     (wbuf_empty)
    );

`ifdef TFT_FB_CLEAR_EN
    clr_state_t           state_r;
    clr_state_t           state_nxt;
    logic [FB_ADDR_W-1:0] cnt_r;
    logic [FB_ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_r <= CLR_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // Sweep yields to display reads; the counter only advances on cycles it owns the RAM.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        sweep_wr  = 1'b0;
        case (state_r)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_nxt = CLR_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLR_CLEAR: begin
                if (!fifo_rdreq) begin
                    sweep_wr = 1'b1;
                    cnt_nxt  = cnt_r + FB_ADDR_W'(1);
                    if (cnt_r == FB_ADDR_W'(FB_SIZE - FB_ADDR_W'(1))) state_nxt = CLR_IDLE;
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

    assign sweep_busy = (state_r == CLR_CLEAR);
    assign sweep_addr = cnt_r;
`else
    logic clr_req_unused;

    assign clr_req_unused = clr_req;
    assign sweep_busy     = 1'b0;
    assign sweep_wr       = 1'b0;
    assign sweep_addr     = '0;
`endif

    assign clr_busy    = sweep_busy;
    assign drain       = ~fifo_rdreq & ~sweep_busy & ~wbuf_empty;
    assign head_in_rng = (head_ent.addr < FB_SIZE);

    // SRAM port arbitration; address and write data hold their last value when idle.
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_r;
        ram_wdata = wdata_r;
        if (fifo_rdreq) begin
            if (rd_in_rng) begin
                ram_cs   = 1'b1;
                ram_addr = fifo_raddr;
            end
        end else if (sweep_wr) begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = sweep_addr;
            ram_wdata = '0;
        end else if (drain && head_in_rng) begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = head_ent.addr;
            ram_wdata = head_ent.data;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            addr_r   <= '0;
            wdata_r  <= '0;
            rd_vld_r <= 1'b0;
            hold_r   <= '0;
            wr_oor   <= 1'b0;
        end else begin
            addr_r   <= ram_addr;
            wdata_r  <= ram_wdata;
            rd_vld_r <= fifo_rdreq & rd_in_rng;
            wr_oor   <= drain & ~head_in_rng;
            // An out-of-range read forces zero data even if a prior read is still landing.
            if (fifo_rdreq && !rd_in_rng) hold_r <= '0;
            else if (rd_vld_r)            hold_r <= ram_rdata;
        end
    end

    assign fifo_rdata = rd_vld_r ? ram_rdata : hold_r;

endmodule
